// File: rtl/rand_pkg.sv
// Shared RNG definitions: zero-seed substitute, arbiter FSM states and the
// xorshift64 step used by every consumer of the generator.
package rand_pkg;

  localparam logic [63:0] ZERO_SEED_SUB = 64'h9E37_79B9_7F4A_7C15;

  typedef enum logic {
    WARMUP,
    SERVE
  } rand_arb_state_e;

  function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
    logic [63:0] x1;
    logic [63:0] x2;
    x1 = x ^ (x << 13);
    x2 = x1 ^ (x1 >> 7);
    return x2 ^ (x2 << 17);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         elig,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         win_oh,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic                       any
);

  localparam int          IW = $clog2(NUM_REQ);
  localparam int unsigned N  = NUM_REQ;

  always_comb begin
    int unsigned p;
    p       = 0;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      p = (32'(last_grant) + k) % N;
      if (!any && elig[IW'(p)]) begin
        any     = 1'b1;
        win_idx = IW'(p);
        win_oh  = NUM_REQ'(1) << p;
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin shared xorshift64 generator with seeding/reseeding.
// Optional warm-up discard phase enabled by `define RAND_ARB_WARMUP_EN.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int OUT_W         = 32,
  parameter int WARMUP_ROUNDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                seed,
  input  logic                       reseed,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic [OUT_W-1:0]           rand_data,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);

  logic [63:0]        x;
  logic [63:0]        x_nxt;
  logic [63:0]        x_step;
  logic [63:0]        load_val;
  logic [IW-1:0]      last_grant;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               serving;
  logic               warm_step;
  logic               grant;

  assign x_step   = xorshift64_step(x);
  assign load_val = (seed == '0) ? ZERO_SEED_SUB : seed;
  // Held request of the requester being acked right now must not win again.
  assign elig     = req & ~ack;
  assign grant    = serving & win_any & ~reseed;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .elig       (elig),
    .last_grant (last_grant),
    .win_oh     (win_oh),
    .win_idx    (win_idx),
    .any        (win_any)
  );

`ifdef RAND_ARB_WARMUP_EN
  localparam int CW = (WARMUP_ROUNDS > 1) ? $clog2(WARMUP_ROUNDS) : 1;
  localparam rand_arb_state_e LOAD_STATE = (WARMUP_ROUNDS == 0) ? SERVE : WARMUP;

  rand_arb_state_e state;
  rand_arb_state_e state_nxt;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   wcnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_STATE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (reseed) begin
      state_nxt = LOAD_STATE;
      wcnt_nxt  = '0;
    end else if (state == WARMUP) begin
      if (32'(wcnt) == WARMUP_ROUNDS - 1) begin
        state_nxt = SERVE;
        wcnt_nxt  = '0;
      end else begin
        wcnt_nxt = wcnt + CW'(1);
      end
    end
  end

  assign serving   = (state == SERVE);
  assign warm_step = (state == WARMUP);
  assign busy      = ~serving;
`else
  if (WARMUP_ROUNDS < 0) begin : g_illegal_warmup_rounds
  end

  assign serving   = 1'b1;
  assign warm_step = 1'b0;
  assign busy      = 1'b0;
`endif

  always_comb begin
    x_nxt = x;
    if (rst || reseed) begin
      x_nxt = load_val;
    end else if (grant || warm_step) begin
      x_nxt = x_step;
    end
  end

  always_ff @(posedge clk) begin
    x <= x_nxt;
    if (rst) begin
      ack        <= '0;
      grant_idx  <= '0;
      rand_data  <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else if (grant) begin
      ack        <= win_oh;
      grant_idx  <= win_idx;
      rand_data  <= x_step[63 -: OUT_W];
      last_grant <= win_idx;
    end else begin
      ack <= '0;
    end
  end

endmodule
